// File: rtl/rd_cmd_responder.sv
// rd_cmd_responder: fetches a commanded packet from SRAM into a {data,last} stream then frees its buffer; RD_RESP_STAT_EN adds iStatClr/oPktCnt/oDropCnt
module rd_cmd_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int LEN_W = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
`ifdef RD_RESP_STAT_EN
  input  logic                      iStatClr,
  output logic [15:0]               oPktCnt,
  output logic [15:0]               oDropCnt,
`endif
  input  logic                      iCmdVld,
  output logic                      oCmdRdy,
  input  logic [ADDR_W+LEN_W+4:0]   iCmdPld,
  output logic                      oMemRen,
  output logic [ADDR_W-1:0]         oMemAddr,
  input  logic [DATA_W-1:0]         iMemRdData,
  output logic                      oDataVld,
  input  logic                      iDataRdy,
  output logic [DATA_W:0]           oDataPld,
  output logic [3:0]                oDataDst,
  output logic                      oFreeVld,
  output logic [ADDR_W-1:0]         oFreeAddr,
  input  logic                      iFreeRdy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + 5;
  typedef enum logic [1:0] {IDLE, READ, WAIT, FREE} state_t;
  state_t state, stateNxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] len, beat;
  logic [3:0] dst, inflightDst;
  logic inflight, inflightLast;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic room, cmdHs, push, pop, lastRead;
  assign room = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
  assign oCmdRdy = state == IDLE && !iRst;
  assign cmdHs = iCmdVld && oCmdRdy;
  assign lastRead = beat == len;
  assign oMemRen = state == READ && room;
  assign oMemAddr = state == READ ? addr + ADDR_W'(beat) : '0;
  assign oFreeVld = state == FREE;
  assign oFreeAddr = oFreeVld ? addr : '0;
  assign push = inflight;
  assign pop = oDataVld && iDataRdy;
  assign oDataVld = count != '0;
  assign oDataPld = oDataVld ? mem[rdPtr][EW-1:4] : '0;
  assign oDataDst = oDataVld ? mem[rdPtr][3:0] : '0;
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: stateNxt = cmdHs ? (iCmdPld[0] ? FREE : READ) : IDLE;
      READ: stateNxt = (oMemRen && lastRead) ? WAIT : READ;
      WAIT: stateNxt = FREE;
      FREE: stateNxt = iFreeRdy ? IDLE : FREE;
      default: stateNxt = IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      inflight <= 1'b0;
      inflightLast <= 1'b0;
      inflightDst <= '0;
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      addr <= '0;
      len <= '0;
      dst <= '0;
      beat <= '0;
    end else begin
      state <= stateNxt;
      inflight <= oMemRen;
      if (cmdHs) begin
        {addr, len, dst} <= iCmdPld[ADDR_W+LEN_W+4:1];
        beat <= '0;
      end
      if (oMemRen) begin
        beat <= beat + LEN_W'(1);
        inflightLast <= lastRead;
        inflightDst <= dst;
      end
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= {iMemRdData, inflightLast, inflightDst};
  end
  always_ff @(posedge iClk) begin
    if (!iRst && push) assert (count != CW'(FIFO_DEPTH)) else $error("rd_cmd_responder fifo overflow");
  end
`ifdef RD_RESP_STAT_EN
  logic drop, freeHs;
  assign freeHs = oFreeVld && iFreeRdy;
  always_ff @(posedge iClk) begin
    if (iRst) drop <= 1'b0;
    else if (cmdHs) drop <= iCmdPld[0];
  end
  always_ff @(posedge iClk) begin
    if (iRst || iStatClr) begin
      oPktCnt <= '0;
      oDropCnt <= '0;
    end else if (freeHs) begin
      if (!drop && oPktCnt != '1) oPktCnt <= oPktCnt + 16'd1;
      if (drop && oDropCnt != '1) oDropCnt <= oDropCnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rd_cmd_responder.sv
// tb_rd_cmd_responder: directed self-checking bench for rd_cmd_responder
module tb_rd_cmd_responder;
  logic iClk = 1'b0, iRst = 1'b1, iCmdVld = 1'b0, iDataRdy = 1'b1, iFreeRdy = 1'b1;
  logic [18:0] iCmdPld = '0;
  logic [63:0] iMemRdData = '0;
  logic oCmdRdy, oMemRen, oDataVld, oFreeVld;
  logic [9:0] oMemAddr, oFreeAddr;
  logic [64:0] oDataPld;
  logic [3:0] oDataDst;
  int vecs = 0, fails = 0;
`ifdef RD_RESP_STAT_EN
  logic iStatClr = 1'b0;
  logic [15:0] oPktCnt, oDropCnt;
`endif
  rd_cmd_responder dut (
    .iClk(iClk), .iRst(iRst),
`ifdef RD_RESP_STAT_EN
    .iStatClr(iStatClr), .oPktCnt(oPktCnt), .oDropCnt(oDropCnt),
`endif
    .iCmdVld(iCmdVld), .oCmdRdy(oCmdRdy), .iCmdPld(iCmdPld),
    .oMemRen(oMemRen), .oMemAddr(oMemAddr), .iMemRdData(iMemRdData),
    .oDataVld(oDataVld), .iDataRdy(iDataRdy), .oDataPld(oDataPld), .oDataDst(oDataDst),
    .oFreeVld(oFreeVld), .oFreeAddr(oFreeAddr), .iFreeRdy(iFreeRdy)
  );
  always #5 iClk = ~iClk;
  function automatic logic [63:0] mw(input logic [9:0] a);
    return {48'hC0DE_5A5A_0000, 6'd0, a};
  endfunction
  always @(posedge iClk) if (oMemRen) iMemRdData <= mw(oMemAddr);
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cmd(input logic [9:0] a, input logic [3:0] l, input logic [3:0] d, input logic dr);
    iCmdPld = {a, l, d, dr};
    iCmdVld = 1'b1;
    check("cmdRdy", oCmdRdy, 1'b1);
    tick();
    iCmdVld = 1'b0;
  endtask
  task automatic runPkt(input logic [9:0] a, input logic [3:0] l, input logic [3:0] d);
    int n;
    n = int'(l);
    iDataRdy = 1'b1;
    iFreeRdy = 1'b1;
    cmd(a, l, d, 1'b0);
    for (int i = 1; i <= n + 4; i++) begin
      check("ren", oMemRen, i <= n + 1);
      if (i <= n + 1) check("memAddr", oMemAddr, 10'(a + i - 1));
      check("dataVld", oDataVld, i >= 3 && i <= n + 3);
      if (i >= 3 && i <= n + 3) begin
        check("dataPld", oDataPld, {mw(10'(a + i - 3)), i == n + 3});
        check("dataDst", oDataDst, d);
      end
      check("freeVld", oFreeVld, i == n + 3);
      if (i == n + 3) check("freeAddr", oFreeAddr, a);
      if (i < n + 4) tick();
    end
    check("idleRdy", oCmdRdy, 1'b1);
  endtask
  initial begin
    int reads, k;
    logic ok;
    logic [64:0] ep [3];
    logic [3:0] ed [3];
    tick();
    tick();
    check("rstCmdRdy", oCmdRdy, 1'b0);
    check("rstMemRen", oMemRen, 1'b0);
    check("rstMemAddr", oMemAddr, 10'h0);
    check("rstDataVld", oDataVld, 1'b0);
    check("rstDataPld", oDataPld, 65'h0);
    check("rstDataDst", oDataDst, 4'h0);
    check("rstFreeVld", oFreeVld, 1'b0);
    check("rstFreeAddr", oFreeAddr, 10'h0);
    iRst = 1'b0;
    tick();
    runPkt(10'h010, 4'd3, 4'd6);
    iFreeRdy = 1'b0;
    cmd(10'h020, 4'd0, 4'd0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      check("dropRen", oMemRen, 1'b0);
      check("dropVld", oDataVld, 1'b0);
      check("dropFreeVld", oFreeVld, 1'b1);
      check("dropFreeAddr", oFreeAddr, 10'h020);
      if (i < 3) tick();
    end
    iFreeRdy = 1'b1;
    tick();
    check("dropDoneFree", oFreeVld, 1'b0);
    check("dropDoneRdy", oCmdRdy, 1'b1);
    runPkt(10'h3FE, 4'd3, 4'd1);
    iDataRdy = 1'b0;
    cmd(10'h100, 4'd15, 4'd3, 1'b0);
    reads = 0;
    for (int i = 1; i <= 10; i++) begin
      reads += int'(oMemRen);
      if (i >= 3) begin
        check("stallVld", oDataVld, 1'b1);
        check("stallPld", oDataPld, {mw(10'h100), 1'b0});
      end
      if (i < 10) tick();
    end
    check("stallReads", reads, 4);
    iDataRdy = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 16; c++) begin
      reads += int'(oMemRen);
      if (oDataVld) begin
        check("bpPld", oDataPld, {mw(10'(10'h100 + k)), k == 15});
        check("bpDst", oDataDst, 4'd3);
        k++;
      end
      tick();
    end
    check("bpBeats", k, 16);
    check("bpReads", reads, 16);
    tick();
    check("bpIdle", oCmdRdy, 1'b1);
    check("bpEmpty", oDataVld, 1'b0);
    iDataRdy = 1'b0;
    cmd(10'h200, 4'd1, 4'd2, 1'b0);
    iCmdPld = {10'h300, 4'd0, 4'd9, 1'b0};
    iCmdVld = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = oCmdRdy;
      tick();
    end
    iCmdVld = 1'b0;
    check("bAccepted", ok, 1'b1);
    check("aPending", oDataVld, 1'b1);
    ep[0] = {mw(10'h200), 1'b0};
    ep[1] = {mw(10'h201), 1'b1};
    ep[2] = {mw(10'h300), 1'b1};
    ed[0] = 4'd2;
    ed[1] = 4'd2;
    ed[2] = 4'd9;
    iDataRdy = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      if (oDataVld) begin
        check("b2bPld", oDataPld, ep[k]);
        check("b2bDst", oDataDst, ed[k]);
        k++;
      end
      tick();
    end
    check("b2bBeats", k, 3);
    tick();
    check("b2bIdle", oCmdRdy, 1'b1);
    check("b2bEmpty", oDataVld, 1'b0);
    cmd(10'h040, 4'd7, 4'd5, 1'b0);
    tick();
    tick();
    check("preRstRen", oMemRen, 1'b1);
    iRst = 1'b1;
    tick();
    check("midRstVld", oDataVld, 1'b0);
    check("midRstRen", oMemRen, 1'b0);
    check("midRstFree", oFreeVld, 1'b0);
    check("midRstRdy", oCmdRdy, 1'b0);
    check("midRstPld", oDataPld, 65'h0);
    iRst = 1'b0;
    tick();
    check("postRstRdy", oCmdRdy, 1'b1);
    check("postRstFree", oFreeVld, 1'b0);
    check("postRstVld", oDataVld, 1'b0);
    runPkt(10'h050, 4'd2, 4'd4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/rd_cmd_responder.md
Name: rd_cmd_responder

Overview:
- Per-port read-command responder sitting directly upstream of the read scheduler's read-data input.
- Consumes one read command (packet base address, beat count, destination port, drop flag) from the scheduler's read-command output.
- Fetches the packet beats from the port's packet-buffer SRAM and returns them as a data/last stream to the scheduler's read-data input.
- Releases the packet's buffer handle to the free-address manager once the packet has been read or dropped.

Parameters:
- ADDR_W, 10, packet-buffer address width (matches global ADDR_LENTH).
- DATA_W, 64, data beat width (matches global DATA_WIDTH).
- LEN_W, 4, beat-count field width; the field encodes beats-1, so 1..16 beats.
- FIFO_DEPTH, 4, output buffer depth in entries; power of two, minimum 4.

Ports:
- iClk  in  1  clock.
- iRst  in  1  synchronous reset, active-high.
- iCmdVld  in  1  read command valid.
- oCmdRdy  out  1  read command ready.
- iCmdPld  in  ADDR_W+LEN_W+5  packed as {addr[ADDR_W-1:0], len[LEN_W-1:0], dst[3:0], drop}.
- oMemRen  out  1  SRAM read enable.
- oMemAddr  out  ADDR_W  SRAM read address.
- iMemRdData  in  DATA_W  SRAM read data, valid exactly 1 cycle after oMemRen.
- oDataVld  out  1  read-data beat valid.
- iDataRdy  in  1  read-data beat ready.
- oDataPld  out  DATA_W+1  packed as {data, last}.
- oDataDst  out  4  destination port of the current beat.
- oFreeVld  out  1  buffer release request.
- oFreeAddr  out  ADDR_W  base address being released.
- iFreeRdy  in  1  release accepted.

Behaviour:
- Reset values: oCmdRdy=0, oMemRen=0, oMemAddr=0, oDataVld=0, oDataPld=0, oDataDst=0, oFreeVld=0, oFreeAddr=0.
- Reset effects: FSM returns to IDLE, FIFO is emptied, the in-flight flag is cleared. Reset mid-packet discards all partial state; no free is issued for the aborted packet.
- FSM states: IDLE, READ, WAIT, FREE.
- IDLE:
  - oCmdRdy=1; this is the only state where it is 1.
  - On iCmdVld&&oCmdRdy: latch addr, len, dst; clear the beat counter.
  - drop=1 goes to FREE; drop=0 goes to READ.
- READ:
  - oMemRen=1 when (fifo_count + inflight) < FIFO_DEPTH.
  - oMemAddr = latched addr + beat, truncated modulo 2^ADDR_W (wrap-around allowed).
  - Beat counter increments on each oMemRen.
  - The read issued with beat==len moves the FSM to WAIT.
- WAIT: one cycle while the last read returns; then to FREE.
- FREE:
  - oFreeVld=1, oFreeAddr=latched addr; both held until iFreeRdy.
  - On iFreeRdy handshake, return to IDLE.
  - A new command may be accepted in IDLE while the FIFO still drains the previous packet.
- Read return path:
  - inflight is a 1-bit register set by oMemRen and cleared when the data returns.
  - Returned data is pushed into the FIFO with last=(beat==len) of the issuing read and dst of its packet.
  - Push and pop in the same cycle is legal; count is unchanged.
  - The FIFO never overflows by construction; a push while full is a design error, flagged by an assertion.
- Output handshake:
  - oDataVld = FIFO non-empty; oDataPld and oDataDst are driven from the FIFO head.
  - Pop on oDataVld&&iDataRdy.
  - Payload must stay stable while oDataVld&&!iDataRdy.
- Latency with no backpressure: command handshake in cycle T, oMemRen in T+1, data pushed at end of T+2, oDataVld in T+3.
- Throughput: 1 beat/cycle sustained. A len=15 packet's last beat appears in T+18.
- Drop path: no SRAM reads and no data beats; oFreeVld asserts in T+1.
- Backpressure: iDataRdy=0 stalls reads once fifo_count+inflight reaches FIFO_DEPTH; reads resume the cycle after a pop frees space.

Optional Feature:
- Macro: RD_RESP_STAT_EN.
- When defined, adds output oPktCnt[15:0] (incremented on each free handshake for a non-drop packet) and oDropCnt[15:0] (incremented on each free handshake for a drop packet).
  - Both counters are saturating and are reset to 0.
  - Stat input iStatClr clears both counters; if it coincides with an increment, the clear wins.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single packet, addr=0x010, len=3, dst=6, iDataRdy=1 -> oMemAddr 0x010..0x013 in T+1..T+4; 4 beats T+3..T+6, last=1 only on the 4th beat, oDataDst=6; oFreeVld with oFreeAddr=0x010.
- Drop command, addr=0x020, drop=1 -> no oMemRen, no oDataVld; oFreeVld=1 with oFreeAddr=0x020 in T+1, held 3 cycles while iFreeRdy=0.
- Wrap: addr=0x3FE (ADDR_W=10), len=3 -> oMemAddr 0x3FE, 0x3FF, 0x000, 0x001.
- Backpressure: len=15, iDataRdy=0 for 10 cycles then 1 -> exactly 4 reads issued before the stall; all 16 beats delivered in order with correct data; payload stable while stalled.
- Back-to-back: command A (len=1, dst=2) then B (len=0, dst=9) with iFreeRdy=1 -> B accepted before A's beats drain; beats arrive A0, A1(last), B0(last) with dst 2, 2, 9.
- Reset mid-packet: iRst asserted during READ of a len=7 packet -> next cycle oDataVld=0, oMemRen=0, oFreeVld=0, oCmdRdy=0, FSM in IDLE; the next command is processed normally.
